// File: rtl/pc_redirect_unit_pkg.sv
// Shared definitions for the PC redirect unit: datapath width, instruction
// size, FSM state encoding and the JALR target helper.
package pc_redirect_unit_pkg;

  localparam int unsigned XLEN        = 32;
  localparam int unsigned INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_TRAP  = 2'd3
  } pc_state_e;

  // JALR target: base + offset with bit 0 forced to zero
  function automatic logic [XLEN-1:0] jalr_target(input logic [XLEN-1:0] base,
                                                  input logic [XLEN-1:0] ofs);
    logic [XLEN-1:0] sum;
    sum = base + ofs;
    return {sum[XLEN-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/branch_target_gen.sv
// Combinational redirect decision: taken flag, target address and
// instruction-address-misaligned flag for the EX-stage control-flow instruction.
module branch_target_gen
  import pc_redirect_unit_pkg::*;
(
  input  logic            i_branch,
  input  logic            i_is_branch,
  input  logic            i_is_jal,
  input  logic            i_is_jalr,
  input  logic [XLEN-1:0] i_ex_pc,
  input  logic [XLEN-1:0] i_imm,
  input  logic [XLEN-1:0] i_rs1_val,
  output logic            o_taken,
  output logic [XLEN-1:0] o_target,
  output logic            o_misaligned
);

  logic [XLEN-1:0] w_pc_rel_tgt;
  logic [XLEN-1:0] w_jalr_tgt;

  // Select target by decode priority jalr > jal > branch; jal and branch share pc+imm
  always_comb begin
    w_pc_rel_tgt = i_ex_pc + i_imm;
    w_jalr_tgt   = jalr_target(i_rs1_val, i_imm);
    o_taken      = i_is_jalr | i_is_jal | (i_is_branch & i_branch);
    o_target     = i_is_jalr ? w_jalr_tgt : w_pc_rel_tgt;
    o_misaligned = o_target[1];
  end

endmodule

// File: rtl/pc_redirect_unit.sv
// Program counter owner for the RV32I core: sequential fetch with a
// valid/ready handshake, redirect on taken branch/jump with a fixed-length
// flush, and an absorbing trap on a misaligned target.
// Optional build macro REDIRECT_COUNTER_EN adds the redirect_cnt output.
module pc_redirect_unit
  import pc_redirect_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned     FLUSH_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  input  logic            stall,
  input  logic            imem_ready,
  output logic [XLEN-1:0] pc_out,
  output logic            pc_valid,
  output logic            flush,
  output logic [XLEN-1:0] link_addr,
  output logic            misaligned
`ifdef REDIRECT_COUNTER_EN
  ,
  output logic [31:0]     redirect_cnt
`endif
);

  pc_state_e       r_state, w_state_nxt;
  logic [XLEN-1:0] r_pc, w_pc_nxt;
  logic [3:0]      r_cnt, w_cnt_nxt;
  logic            r_mis, w_mis_nxt;

  logic            w_taken;
  logic [XLEN-1:0] w_target;
  logic            w_tgt_mis;

  branch_target_gen u_btg (
    .i_branch     (branch),
    .i_is_branch  (is_branch),
    .i_is_jal     (is_jal),
    .i_is_jalr    (is_jalr),
    .i_ex_pc      (ex_pc),
    .i_imm        (imm),
    .i_rs1_val    (rs1_val),
    .o_taken      (w_taken),
    .o_target     (w_target),
    .o_misaligned (w_tgt_mis)
  );

  // State, PC, flush counter and sticky misaligned flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_VECTOR;
      r_cnt   <= '0;
      r_mis   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_mis   <= w_mis_nxt;
    end
  end

  // Next-state and next-PC selection; a redirect in RUN wins over stall/ready
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_cnt_nxt   = r_cnt;
    w_mis_nxt   = r_mis;
    case (r_state)
      S_BOOT: w_state_nxt = S_RUN;
      S_RUN: begin
        if (w_taken) begin
          if (w_tgt_mis) begin
            w_state_nxt = S_TRAP;
            w_mis_nxt   = 1'b1;
          end else begin
            w_state_nxt = S_FLUSH;
            w_pc_nxt    = w_target;
            w_cnt_nxt   = 4'(FLUSH_CYCLES - 1);
          end
        end else if (imem_ready && !stall) begin
          w_pc_nxt = r_pc + XLEN'(INSTR_BYTES);
        end
      end
      S_FLUSH: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_RUN;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_TRAP: w_state_nxt = S_TRAP;
      default: w_state_nxt = S_BOOT;
    endcase
  end

  // Outputs decoded from state; link address is independent of state
  always_comb begin
    pc_out     = r_pc;
    pc_valid   = (r_state == S_RUN);
    flush      = (r_state == S_FLUSH) || (r_state == S_TRAP);
    misaligned = r_mis;
    link_addr  = ex_pc + XLEN'(INSTR_BYTES);
  end

`ifdef REDIRECT_COUNTER_EN
  logic        w_redirect;
  logic [31:0] r_redirect_cnt;

  // An accepted redirect is one that actually moves the PC to the target
  always_comb begin
    w_redirect = (r_state == S_RUN) && w_taken && !w_tgt_mis;
  end

  // Saturating count of accepted redirects
  always_ff @(posedge clk) begin
    if (rst) begin
      r_redirect_cnt <= '0;
    end else if (w_redirect && (r_redirect_cnt != '1)) begin
      r_redirect_cnt <= r_redirect_cnt + 32'd1;
    end
  end

  assign redirect_cnt = r_redirect_cnt;
`endif

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit (RESET_VECTOR=0x100, FLUSH_CYCLES=2).
module tb_pc_redirect_unit;

  logic        clk = 1'b0;
  logic        rst, branch, is_branch, is_jal, is_jalr, stall, imem_ready;
  logic [31:0] ex_pc, imm, rs1_val;
  logic [31:0] pc_out, link_addr;
  logic        pc_valid, flush, misaligned;
`ifdef REDIRECT_COUNTER_EN
  logic [31:0] redirect_cnt;
`endif

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  logic [34:0] exp_v;

  pc_redirect_unit #(
    .RESET_VECTOR (32'h0000_0100),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .branch     (branch),
    .is_branch  (is_branch),
    .is_jal     (is_jal),
    .is_jalr    (is_jalr),
    .ex_pc      (ex_pc),
    .imm        (imm),
    .rs1_val    (rs1_val),
    .stall      (stall),
    .imem_ready (imem_ready),
    .pc_out     (pc_out),
    .pc_valid   (pc_valid),
    .flush      (flush),
    .link_addr  (link_addr),
    .misaligned (misaligned)
`ifdef REDIRECT_COUNTER_EN
    ,
    .redirect_cnt (redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Observed {pc_valid, flush, misaligned, pc_out}
  function automatic logic [34:0] obs();
    return {pc_valid, flush, misaligned, pc_out};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_decode();
    branch = 1'b0; is_branch = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
    ex_pc = '0; imm = '0; rs1_val = '0;
  endtask

  // Leaves the DUT in RUN at 0x100 with imem_ready=1, stall=0
  task automatic do_reset();
    clear_decode();
    stall = 1'b0; imem_ready = 1'b1; rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    clear_decode();
    stall = 1'b0; imem_ready = 1'b1; rst = 1'b1;
    tick();
    exp_v = {1'b0, 1'b0, 1'b0, 32'h0000_0100}; n_vec++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL reset_state got=%h want=%h", obs(), exp_v); end
    rst = 1'b0;
    tick();
    exp_v = {1'b1, 1'b0, 1'b0, 32'h0000_0100}; n_vec++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL boot_first_fetch got=%h want=%h", obs(), exp_v); end
    tick();
    exp_v = {1'b1, 1'b0, 1'b0, 32'h0000_0104}; n_vec++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL seq_fetch_104 got=%h want=%h", obs(), exp_v); end
    tick();
    exp_v = {1'b1, 1'b0, 1'b0, 32'h0000_0108}; n_vec++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL seq_fetch_108 got=%h want=%h", obs(), exp_v); end
  endtask

  task automatic test_link_addr();
    ex_pc = 32'h0000_1234; #1;
    n_vec++;
    if (link_addr !== 32'h0000_1238) begin n_err++; $display("FAIL link_addr got=%h want=%h", link_addr, 32'h0000_1238); end
    ex_pc = 32'hFFFF_FFFC; #1;
    n_vec++;
    if (link_addr !== 32'h0000_0000) begin n_err++; $display("FAIL link_addr_wrap got=%h want=%h", link_addr, 32'h0000_0000); end
    ex_pc = '0;
  endtask

  task automatic test_ready_stall();
    do_reset();
    is_jal = 1'b1; ex_pc = 32'h0; imm = 32'h10; imem_ready = 1'b0;
    tick();
    clear_decode();
    exp_v = {1'b0, 1'b1, 1'b0, 32'h0000_0010}; n_vec++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL jal_to_10 got=%h want=%h", obs(), exp_v); end
    tick(); tick();
    for (int i = 0; i < 3; i++) begin
      exp_v = {1'b1, 1'b0, 1'b0, 32'h0000_0010}; n_vec++;
      if (obs() !== exp_v) begin n_err++; $display("FAIL not_ready_hold%0d got=%h want=%h", i, obs(), exp_v); end
      if (i < 2) tick();
    end
    imem_ready = 1'b1;
    tick();
    exp_v = {1'b1, 1'b0, 1'b0, 32'h0000_0014}; n_vec++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL ready_advance got=%h want=%h", obs(), exp_v); end
    stall = 1'b1;
    tick(); tick();
    exp_v = {1'b1, 1'b0, 1'b0, 32'h0000_0014}; n_vec++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL stall_hold got=%h want=%h", obs(), exp_v); end
    stall = 1'b0;
    tick();
    exp_v = {1'b1, 1'b0, 1'b0, 32'h0000_0018}; n_vec++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL stall_release got=%h want=%h", obs(), exp_v); end
  endtask

  task automatic test_branch();
    do_reset();
    is_branch = 1'b1; branch = 1'b1; ex_pc = 32'h40; imm = 32'hFFFF_FFF0;
    tick();
    clear_decode();
    exp_v = {1'b0, 1'b1, 1'b0, 32'h0000_0030}; n_vec++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL branch_flush1 got=%h want=%h", obs(), exp_v); end
    tick();
    exp_v = {1'b0, 1'b1, 1'b0, 32'h0000_0030}; n_vec++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL branch_flush2 got=%h want=%h", obs(), exp_v); end
    tick();
    exp_v = {1'b1, 1'b0, 1'b0, 32'h0000_0030}; n_vec++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL branch_resume got=%h want=%h", obs(), exp_v); end
    tick();
    exp_v = {1'b1, 1'b0, 1'b0, 32'h0000_0034}; n_vec++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL branch_seq got=%h want=%h", obs(), exp_v); end
    is_branch = 1'b1; branch = 1'b0; ex_pc = 32'h40; imm = 32'hFFFF_FFF0;
    tick();
    clear_decode();
    exp_v = {1'b1, 1'b0, 1'b0, 32'h0000_0038}; n_vec++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL branch_not_taken got=%h want=%h", obs(), exp_v); end
  endtask

  task automatic test_trap();
    do_reset();
    is_jalr = 1'b1; rs1_val = 32'h203; imm = 32'h4;
    tick();
    exp_v = {1'b0, 1'b1, 1'b1, 32'h0000_0100}; n_vec++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL trap_enter got=%h want=%h", obs(), exp_v); end
    clear_decode();
    is_jal = 1'b1; imm = 32'h20;
    tick(); tick(); tick();
    exp_v = {1'b0, 1'b1, 1'b1, 32'h0000_0100}; n_vec++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL trap_absorb got=%h want=%h", obs(), exp_v); end
    clear_decode();
    rst = 1'b1;
    tick();
    exp_v = {1'b0, 1'b0, 1'b0, 32'h0000_0100}; n_vec++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL trap_reset got=%h want=%h", obs(), exp_v); end
    rst = 1'b0;
    tick();
    is_jalr = 1'b1; rs1_val = 32'h201; imm = 32'h3;
    tick();
    clear_decode();
    exp_v = {1'b0, 1'b1, 1'b0, 32'h0000_0204}; n_vec++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL jalr_aligned got=%h want=%h", obs(), exp_v); end
  endtask

  // Continues from test_trap: DUT is in the first flush cycle toward 0x204
  task automatic test_flush_ignore();
    is_jal = 1'b1; ex_pc = 32'h0; imm = 32'h80;
    tick();
    clear_decode();
    exp_v = {1'b0, 1'b1, 1'b0, 32'h0000_0204}; n_vec++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL flush_ignores_jal got=%h want=%h", obs(), exp_v); end
    tick();
    exp_v = {1'b1, 1'b0, 1'b0, 32'h0000_0204}; n_vec++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL flush_exit got=%h want=%h", obs(), exp_v); end
  endtask

  // Continues from test_flush_ignore: RUN at 0x204
  task automatic test_stall_redirect();
    stall = 1'b1; imem_ready = 1'b0;
    is_jal = 1'b1; ex_pc = 32'h200; imm = 32'h20;
    tick();
    clear_decode();
    stall = 1'b0; imem_ready = 1'b1;
    exp_v = {1'b0, 1'b1, 1'b0, 32'h0000_0220}; n_vec++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL redirect_over_stall got=%h want=%h", obs(), exp_v); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_v = {1'b0, 1'b0, 1'b0, 32'h0000_0100}; n_vec++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL reset_mid_flush got=%h want=%h", obs(), exp_v); end
    tick();
    exp_v = {1'b1, 1'b0, 1'b0, 32'h0000_0100}; n_vec++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL boot_after_flush_reset got=%h want=%h", obs(), exp_v); end
  endtask

  task automatic test_wrap();
    do_reset();
    is_jal = 1'b1; ex_pc = 32'h0; imm = 32'hFFFF_FFFC;
    tick();
    clear_decode();
    tick(); tick();
    exp_v = {1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC}; n_vec++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL wrap_top got=%h want=%h", obs(), exp_v); end
    tick();
    exp_v = {1'b1, 1'b0, 1'b0, 32'h0000_0000}; n_vec++;
    if (obs() !== exp_v) begin n_err++; $display("FAIL wrap_zero got=%h want=%h", obs(), exp_v); end
  endtask

`ifdef REDIRECT_COUNTER_EN
  task automatic test_redirect_counter();
    do_reset();
    n_vec++;
    if (redirect_cnt !== 32'd0) begin n_err++; $display("FAIL cnt_reset got=%0d want=0", redirect_cnt); end
    for (int k = 0; k < 3; k++) begin
      is_jal = 1'b1; ex_pc = 32'h0; imm = 32'h40;
      tick();
      clear_decode();
      tick(); tick();
    end
    n_vec++;
    if (redirect_cnt !== 32'd3) begin n_err++; $display("FAIL cnt_three got=%0d want=3", redirect_cnt); end
  endtask
`endif

  initial begin
    rst = 1'b1; stall = 1'b0; imem_ready = 1'b0;
    clear_decode();
    test_reset();
    test_link_addr();
    test_ready_stall();
    test_branch();
    test_trap();
    test_flush_ignore();
    test_stall_redirect();
    test_wrap();
`ifdef REDIRECT_COUNTER_EN
    test_redirect_counter();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
